program_loader: RTL
===================

// Module: program_loader
// PURPOSE
//  Boot-time loader that sits directly upstream of the single-cycle cpu. It accepts a stream of
//  32-bit instruction words over a valid/ready handshake. It writes them into the cpu's
//  instruction memory through the initialize / instruction_initialize_* port. It then releases
//  the cpu from reset so execution starts at address 0. It owns the cpu's rst input.
// PARAMETERS
//  BASE_ADDR      32'd0   byte address of the first loaded word
//  ADDR_STEP      32'd4   byte increment per loaded word
//  MAX_WORDS      64      instruction memory capacity in words; a stream longer than this is an error
//  RST_HOLD       4       cycles cpu_rst stays high after initialize drops (1..255)
// PORTS
//  clk                             in   1   system clock; all state updates on its rising edge
//  rst                             in   1   asynchronous, active-high reset
//  start                           in   1   1-cycle pulse that begins a load; honoured only in IDLE, RUN or ERROR
//  in_valid                        in   1   in_data/in_last are valid this cycle
//  in_data                         in   32  instruction word
//  in_last                         in   1   marks the final word of the program
//  in_ready                        out  1   loader accepts a word this cycle; accept = in_valid & in_ready
//  initialize                      out  1   drives cpu.initialize
//  instruction_initialize_data     out  32  drives cpu.instruction_initialize_data
//  instruction_initialize_address  out  32  drives cpu.instruction_initialize_address
//  cpu_rst                         out  1   drives cpu.rst
//  done                            out  1   high in RUN: program loaded and cpu released
//  error                           out  1   high in ERROR: overflow (more than MAX_WORDS words)
//  word_count                      out  32  number of words accepted in the current or last load
// BEHAVIOUR
//  - All outputs are registered, except in_ready, which is decoded from state.
//  - Reset (async, any time, including mid-load):
//    - state = IDLE; initialize = 0; cpu_rst = 1; done = 0; error = 0; word_count = 0.
//    - data = 32'h0; address = BASE_ADDR.
//  - States:
//    - IDLE: cpu_rst = 1, in_ready = 0. On start: go to LOAD; initialize <= 1; word_count <= 0;
//      address <= BASE_ADDR; data <= 0.
//    - LOAD: in_ready = 1, initialize = 1. On each accept:
//      - data <= in_data;
//      - address <= BASE_ADDR + word_count*ADDR_STEP;
//      - word_count <= word_count + 1.
//      The instruction memory writes on the next edge, so write latency is 1 cycle after the accept
//      edge. The memory rewrites the currently held word on every idle LOAD cycle (idempotent). On
//      entry it writes 0 (NOP) to BASE_ADDR until the first beat arrives.
//    - LOAD exits:
//      - accept with in_last = 1: go to FLUSH.
//      - accept with in_last = 0 and word_count == MAX_WORDS-1: go to ERROR. That word is still
//        written; this is a full buffer without a last marker.
//      - accept when word_count == MAX_WORDS-1 and in_last = 1: legal; go to FLUSH.
//    - FLUSH: 1 cycle. in_ready = 0, initialize = 1, so the final word's write lands. Then
//      initialize <= 0; load counter = RST_HOLD-1; go to RELEASE.
//    - RELEASE: cpu_rst = 1, initialize = 0. Decrement the counter each cycle; at 0, cpu_rst <= 0,
//      done <= 1, go to RUN. cpu_rst therefore stays high for exactly RST_HOLD cycles after
//      initialize falls.
//    - RUN: cpu_rst = 0, done = 1. On start: done <= 0, cpu_rst <= 1, then proceed as in IDLE
//      (reload).
//    - ERROR: in_ready = 0, initialize <= 0, cpu_rst = 1, error = 1. On start: clear error and
//      proceed as in IDLE.
//  - start is ignored in LOAD/FLUSH/RELEASE.
//  - in_valid is ignored whenever in_ready = 0; no data is lost, the source must hold the word.
//  - start and reset in the same cycle: reset wins.
//  - An accept and start in the same cycle cannot occur, since in_ready = 0 outside LOAD.
//  - Address arithmetic is 32-bit and wraps modulo 2^32; no wrap occurs for legal parameter values.
// TESTING
//  1. Reset mid-LOAD after 3 accepts -> next cycle: initialize = 0, cpu_rst = 1, word_count = 0,
//     state IDLE; a later start reloads from BASE_ADDR.
//  2. start, then 3 words {32'h2008_0005, 32'h2009_0003, 32'h0109_5020} with in_last on the third ->
//     memory words 0/4/8 hold these values; initialize falls 1 cycle after the last accept;
//     cpu_rst falls RST_HOLD = 4 cycles later; done = 1; word_count = 3; cpu ALUOut begins sequencing.
//  3. in_valid toggled randomly with 50% gaps during a 5-word load -> every word is written
//     exactly once, at addresses 0,4,8,12,16, in order; word_count = 5.
//  4. MAX_WORDS = 4, 5 words sent without in_last -> 4th accept goes to ERROR: error = 1,
//     in_ready = 0, cpu_rst = 1, 5th word is not accepted; start clears error and restarts the load.
//  5. in_valid high in IDLE/RUN and start pulsed during LOAD -> in_ready stays 0, no memory writes,
//     load progress is unaffected.
//  6. Reload from RUN: start -> cpu_rst = 1 next cycle, done = 0; a 1-word load with
//     in_last = 1, word 32'hAC00_0000 -> address 0 overwritten, done = 1 after FLUSH + 4 cycles.

Source files
------------

// File: rtl/program_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// program_loader: streams instruction words into the cpu instruction memory,
// then holds cpu reset for RST_HOLD cycles before releasing it.    Rev 1.0
// ----------------------------------------------------------------------------
module program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter logic [31:0] ADDR_STEP = 32'd4,
  parameter int unsigned MAX_WORDS = 64,
  parameter int unsigned RST_HOLD  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        initialize,
  output logic [31:0] instruction_initialize_data,
  output logic [31:0] instruction_initialize_address,
  output logic        cpu_rst,
  output logic        done,
  output logic        error,
  output logic [31:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_FLUSH   = 3'd2,
    S_RELEASE = 3'd3,
    S_RUN     = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  localparam logic [31:0] C_LAST_SLOT = 32'(MAX_WORDS - 1);
  localparam logic [7:0]  C_HOLD_INIT = 8'(RST_HOLD - 1);

  state_t      state_q;
  logic [7:0]  hold_q;
  logic        init_q;
  logic        cpu_rst_q;
  logic        done_q;
  logic        error_q;
  logic [31:0] data_q;
  logic [31:0] addr_q;
  logic [31:0] count_q;

  logic        accept;
  logic        start_load;
  logic [31:0] addr_d;

  assign in_ready   = (state_q == S_LOAD);
  assign accept     = in_valid & in_ready;
  assign start_load = start & ((state_q == S_IDLE) | (state_q == S_RUN) | (state_q == S_ERROR));
  assign addr_d     = BASE_ADDR + count_q * ADDR_STEP;

  assign initialize                     = init_q;
  assign instruction_initialize_data    = data_q;
  assign instruction_initialize_address = addr_q;
  assign cpu_rst                        = cpu_rst_q;
  assign done                           = done_q;
  assign error                          = error_q;
  assign word_count                     = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hold_q    <= 8'd0;
      init_q    <= 1'b0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      data_q    <= 32'h0;
      addr_q    <= BASE_ADDR;
      count_q   <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_LOAD: begin
          if (accept) begin
            data_q  <= in_data;
            addr_q  <= addr_d;
            count_q <= count_q + 32'd1;
            if (in_last) begin
              state_q <= S_FLUSH;
            end else if (count_q == C_LAST_SLOT) begin
              // initialize stays high one more cycle so the overflowing word still lands
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end
          end
        end
        S_FLUSH: begin
          init_q  <= 1'b0;
          hold_q  <= C_HOLD_INIT;
          state_q <= S_RELEASE;
        end
        S_RELEASE: begin
          if (hold_q == 8'd0) begin
            cpu_rst_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_RUN;
          end else begin
            hold_q <= hold_q - 8'd1;
          end
        end
        S_RUN: ;
        S_ERROR: init_q <= 1'b0;
        default: state_q <= S_IDLE;
      endcase

      // A (re)load request overrides whatever the state above scheduled
      if (start_load) begin
        state_q   <= S_LOAD;
        init_q    <= 1'b1;
        cpu_rst_q <= 1'b1;
        done_q    <= 1'b0;
        error_q   <= 1'b0;
        count_q   <= 32'd0;
        addr_q    <= BASE_ADDR;
        data_q    <= 32'h0;
      end
    end
  end

endmodule
`default_nettype wire
